// File: rtl/alu_arb.sv
// Two-requester ALU with round-robin arbitration and an IDLE/EXEC two-state controller.
// ack is combinational in IDLE; result and flags are registered at the end of EXEC.
module alu_arb (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req0,
   input  logic [2:0]  i_op0,
   input  logic [31:0] i_a0,
   input  logic [31:0] i_b0,
   output logic        o_ack0,
   output logic        o_done0,
   input  logic        i_req1,
   input  logic [2:0]  i_op1,
   input  logic [31:0] i_a1,
   input  logic [31:0] i_b1,
   output logic        o_ack1,
   output logic        o_done1,
   output logic [31:0] o_result,
   output logic        o_zf,
   output logic        o_sf
);

   typedef enum logic {StIdle, StExec} state_e;

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpOr  = 3'b001;
   localparam logic [2:0] OpAnd = 3'b100;
   localparam logic [2:0] OpSub = 3'b101;
   localparam logic [2:0] OpXor = 3'b110;
   localparam logic [2:0] OpCmp = 3'b111;

   state_e      r_state;
   logic        r_last;   // 1: requester 1 was granted last
   logic        r_gnt;    // requester owning the in-flight operation
   logic [2:0]  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_result;
   logic        r_zf;
   logic        r_sf;

   logic        w_idle;
   logic        w_exec;
   logic        w_gnt0;
   logic        w_gnt1;
   logic [31:0] w_res;
   logic        w_upd_res;

   assign w_idle = (r_state == StIdle) && !i_rst;
   assign w_exec = (r_state == StExec) && !i_rst;
   assign w_gnt0 = w_idle && i_req0 && (!i_req1 || r_last);
   assign w_gnt1 = w_idle && i_req1 && (!i_req0 || !r_last);

   always_comb begin
      w_res     = '0;
      w_upd_res = 1'b1;
      case (r_op)
         OpAdd:   w_res = r_a + r_b;
         OpOr:    w_res = r_a | r_b;
         OpAnd:   w_res = r_a & r_b;
         OpSub:   w_res = r_b - r_a;
         OpXor:   w_res = r_a ^ r_b;
         OpCmp: begin
            w_res     = r_b - r_a;
            w_upd_res = 1'b0;
         end
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_last   <= 1'b1;
         r_gnt    <= 1'b0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_zf     <= 1'b0;
         r_sf     <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_gnt0 || w_gnt1) begin
                  r_op    <= w_gnt1 ? i_op1 : i_op0;
                  r_a     <= w_gnt1 ? i_a1 : i_a0;
                  r_b     <= w_gnt1 ? i_b1 : i_b0;
                  r_gnt   <= w_gnt1;
                  r_last  <= w_gnt1;
                  r_state <= StExec;
               end
            end
            StExec: begin
               if (w_upd_res) r_result <= w_res;
               r_zf    <= (w_res == 32'd0);
               r_sf    <= w_res[31];
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_ack0   = w_gnt0;
   assign o_ack1   = w_gnt1;
   assign o_done0  = w_exec && !r_gnt;
   assign o_done1  = w_exec && r_gnt;
   assign o_result = r_result;
   assign o_zf     = r_zf;
   assign o_sf     = r_sf;

endmodule

// File: tb/tb_alu_arb.sv
// Directed and randomized checks of alu_arb against a transaction-level reference model.
module tb_alu_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [2:0]  op0 = '0, op1 = '0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic        ack0, ack1, done0, done1, zf, sf;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   // Reference model: one pending job, last-granted pointer and the visible result registers.
   bit          m_busy = 0;
   bit          m_who = 0;
   bit          m_last = 1;
   logic [2:0]  m_op = '0;
   logic [31:0] m_a = '0, m_b = '0;
   logic [31:0] m_result = '0;
   logic        m_zf = 0, m_sf = 0;
   logic        e_ack0, e_ack1;

   alu_arb u_dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_req0   (req0),
      .i_op0    (op0),
      .i_a0     (a0),
      .i_b0     (b0),
      .o_ack0   (ack0),
      .o_done0  (done0),
      .i_req1   (req1),
      .i_op1    (op1),
      .i_a1     (a1),
      .i_b1     (b1),
      .o_ack1   (ack1),
      .o_done1  (done1),
      .o_result (result),
      .o_zf     (zf),
      .o_sf     (sf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic q0, input logic [2:0] o0, input logic [31:0] x0,
                        input logic [31:0] y0, input logic q1, input logic [2:0] o1,
                        input logic [31:0] x1, input logic [31:0] y1);
      rst = r; req0 = q0; op0 = o0; a0 = x0; b0 = y0;
      req1 = q1; op1 = o1; a1 = x1; b1 = y1;
      #1;
   endtask

   // Compare one cycle against the model, then advance model and DUT across the clock edge.
   task automatic step();
      logic [31:0] d;
      e_ack0 = !rst && !m_busy && req0 && (!req1 || m_last);
      e_ack1 = !rst && !m_busy && req1 && (!req0 || !m_last);
      chk("ack0", {31'd0, ack0}, {31'd0, e_ack0});
      chk("ack1", {31'd0, ack1}, {31'd0, e_ack1});
      chk("done0", {31'd0, done0}, {31'd0, !rst && m_busy && !m_who});
      chk("done1", {31'd0, done1}, {31'd0, !rst && m_busy && m_who});
      chk("result", result, m_result);
      chk("flags", {30'd0, zf, sf}, {30'd0, m_zf, m_sf});
      @(posedge clk);
      if (rst) begin
         m_busy = 0; m_last = 1; m_result = '0; m_zf = 0; m_sf = 0;
      end else if (m_busy) begin
         d = 32'd0;
         case (m_op)
            3'd0: d = m_a + m_b;
            3'd1: d = m_a | m_b;
            3'd4: d = m_a & m_b;
            3'd5, 3'd7: d = m_b - m_a;
            3'd6: d = m_a ^ m_b;
            default: d = 32'd0;
         endcase
         if (m_op != 3'd7) m_result = d;
         m_zf = (d == 32'd0);
         m_sf = d[31];
         m_busy = 0;
      end else if (e_ack0 || e_ack1) begin
         m_who = e_ack1; m_last = e_ack1; m_busy = 1;
         m_op = e_ack1 ? op1 : op0;
         m_a  = e_ack1 ? a1 : a0;
         m_b  = e_ack1 ? b1 : b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
   endtask

   initial begin
      logic [31:0] r;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      do_reset();
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {30'd0, zf, sf}, 32'd0);

      // ADD 5+7 from requester 0
      drive(0, 1, 3'b000, 5, 7, 0, 0, 0, 0);
      chk("add_ack0", {31'd0, ack0}, 32'd1);
      step();
      drive(0, 0, 3'b010, 32'hdead, 32'hbeef, 0, 0, 0, 0);
      chk("add_done0", {31'd0, done0}, 32'd1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("add_result", result, 32'd12);
      chk("add_flags", {30'd0, zf, sf}, 32'd0);
      step();

      // CMP keeps result, updates flags from b-a
      drive(0, 0, 0, 0, 0, 1, 3'b111, 9, 4);
      chk("cmp_ack1", {31'd0, ack1}, 32'd1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("cmp_done1", {31'd0, done1}, 32'd1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("cmp_result", result, 32'd12);
      chk("cmp_flags", {30'd0, zf, sf}, 32'd1);
      step();

      // Undefined opcode
      drive(0, 1, 3'b011, 1, 1, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("undef_done0", {31'd0, done0}, 32'd1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("undef_result", result, 32'd0);
      chk("undef_flags", {30'd0, zf, sf}, 32'd2);
      step();

      // Simultaneous requests from reset: requester 0 first
      do_reset();
      drive(0, 1, 3'b101, 3, 3, 1, 3'b110, 32'hF0F0_0000, 32'h0F0F_0000);
      chk("tie_ack", {30'd0, ack0, ack1}, 32'd2);
      step();
      drive(0, 0, 0, 0, 0, 1, 3'b110, 32'hF0F0_0000, 32'h0F0F_0000);
      chk("tie_done0", {30'd0, done0, ack1}, 32'd2);
      step();
      drive(0, 0, 0, 0, 0, 1, 3'b110, 32'hF0F0_0000, 32'h0F0F_0000);
      chk("sub_zero", {result[31:0]}, 32'd0);
      chk("sub_zf", {31'd0, zf}, 32'd1);
      chk("tie_ack1", {31'd0, ack1}, 32'd1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("tie_done1", {31'd0, done1}, 32'd1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("xor_result", result, 32'hFFFF_0000);
      chk("xor_flags", {30'd0, zf, sf}, 32'd1);
      step();

      // Both held continuously: acks alternate 0,1,0,1 every other cycle
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 3'b000, i, 1, 1, 3'b001, i, 2);
         chk("rr_pattern", {30'd0, ack0, ack1},
             (i % 2 != 0) ? 32'd0 : (((i / 2) % 2 != 0) ? 32'd1 : 32'd2));
         step();
      end

      // Reset during EXEC aborts the operation
      do_reset();
      drive(0, 1, 3'b000, 5, 7, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 0, 0, 1, 0, 1, 1);
      chk("abort_done", {30'd0, done0, done1}, 32'd0);
      chk("abort_ack", {30'd0, ack0, ack1}, 32'd0);
      step();
      drive(0, 1, 3'b000, 1, 1, 0, 0, 0, 0);
      chk("abort_result", result, 32'd0);
      chk("abort_flags", {30'd0, zf, sf}, 32'd0);
      chk("abort_idle", {31'd0, ack0}, 32'd1);
      step();

      // Randomized traffic: requests held until ack, occasionally withdrawn
      for (int n = 0; n < 3000; n++) begin
         r = $urandom;
         rst = ($urandom_range(0, 59) == 0);
         if (req0 && (e_ack0 || $urandom_range(0, 15) == 0)) req0 = 0;
         else if (!req0 && $urandom_range(0, 2) == 0) req0 = 1;
         if (req1 && (e_ack1 || $urandom_range(0, 15) == 0)) req1 = 0;
         else if (!req1 && $urandom_range(0, 2) == 0) req1 = 1;
         if (!req0 || e_ack0) begin
            op0 = 3'($urandom); a0 = $urandom; b0 = r[0] ? a0 : $urandom;
         end
         if (!req1 || e_ack1) begin
            op1 = 3'($urandom); a1 = $urandom; b1 = r[1] ? a1 : $urandom;
         end
         #1;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 req0  input  1  requester 0 operation request; SHALL be held high until ack0.
REQ-004 op0  input  3  requester 0 opcode.
REQ-005 a0, b0  input  32 each  requester 0 operands.
REQ-006 ack0  output  1  one-cycle pulse; requester 0 operands captured.
REQ-007 done0  output  1  one-cycle pulse; result/flags for requester 0 valid.
REQ-008 req1, op1, a1, b1, ack1, done1  same widths/meaning as REQ-003..007, for requester 1.
REQ-009 result  output  32  registered ALU result, shared by both requesters.
REQ-010 zf  output  1  registered zero flag: result-of-operation == 0.
REQ-011 sf  output  1  registered sign flag: bit 31 of result-of-operation.

Function
REQ-012 Opcode encoding SHALL be: ADD 000 (a+b), SUB 101 (b-a), CMP 111 (b-a), AND 100, OR 001, XOR 110; 010 and 011 undefined.
REQ-013 Arithmetic SHALL be 32-bit modulo 2^32; no carry/overflow output.
REQ-014 FSM states SHALL be IDLE and EXEC only.
REQ-015 IDLE, no req: stay IDLE, no ack, no done.
REQ-016 IDLE, any req: grant one requester; capture its op/a/b into internal registers; pulse its ack in the same cycle (combinational from state and req); next state EXEC.
REQ-017 Arbitration SHALL be round-robin: single req wins; on simultaneous req0&req1, the requester not granted last wins.
REQ-018 Last-granted pointer SHALL update only on a grant.
REQ-019 EXEC: compute from captured operands; register result and flags; pulse done of the granted requester for exactly this cycle; next state IDLE.
REQ-020 Latency: ack cycle N, done cycle N+1, result/zf/sf valid from cycle N+2 and held until the next EXEC updates them.
REQ-021 Throughput: at most one grant per 2 cycles; a req high in EXEC SHALL not be acked until the following IDLE cycle.
REQ-022 ADD, SUB, AND, OR, XOR SHALL update result, zf and sf.
REQ-023 CMP SHALL update zf and sf from b-a and leave result unchanged.
REQ-024 Undefined opcode SHALL set result to 0, zf=1, sf=0, and still pulse done.
REQ-025 req deasserted before ack: no grant, no state change.
REQ-026 Operand/op input changes after ack SHALL not affect the in-flight operation.
REQ-027 ack0/ack1 and done0/done1 SHALL never be high in the same cycle as each other.

Reset
REQ-028 rst high at a clock edge SHALL force: state IDLE, result 0, zf 0, sf 0, pointer = requester 1 (so requester 0 wins first tie).
REQ-029 ack and done SHALL be low while rst is high.
REQ-030 rst during EXEC SHALL abort the operation: no done pulse, result/flags take reset values.
REQ-031 Reset SHALL take precedence over any simultaneous request.

Verification
REQ-032 After reset, req0 only, op0=000, a0=5, b0=7 -> ack0 at N, done0 at N+1, result=12, zf=0, sf=0.
REQ-033 req0&req1 together from reset, req0 op=101 a=3 b=3, req1 op=110 a=F0F0_0000 b=0F0F_0000 -> ack0 N, done0 N+1 (result 0, zf=1); ack1 N+2, done1 N+3 (result FFFF_0000, sf=1).
REQ-034 Result=12 held, then req1 CMP a=9 b=4 -> done1, result stays 12, zf=0, sf=1.
REQ-035 req0 op=011 a=1 b=1 -> done0, result=0, zf=1, sf=0.
REQ-036 Both reqs held continuously for 8 cycles -> acks alternate 0,1,0,1 at 2-cycle spacing.
REQ-037 rst asserted in EXEC cycle of an ADD -> no done, result=0, zf=0, sf=0, IDLE next.
